// File: rtl/pe_op_sequencer.sv
// Drives one PE through a DOT, ELEM or DIST operation by stepping its control
// fields (Sel_cu, Sel_cu_go_back, Sel_adder, Is_save_cu_out) on a fixed cadence.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for Start; Ready=1, all PE controls 0
//   S_STEP   | holding the current step's controls for STEP_CYCLES cycles
//   S_DRAIN  | last step's controls held while the PE/adder tree settles
//   S_FINISH | single cycle: controls cleared, Done pulses
module pe_op_sequencer #(
   parameter int STEP_CYCLES  = 10,
   parameter int DRAIN_CYCLES = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Start,
   input  logic [1:0] Op,
   input  logic       Abort,
   output logic       Ready,
   output logic       Busy,
   output logic       Done,
   output logic       Err,
   output logic [2:0] Step_idx,
   output logic [1:0] Sel_cu,
   output logic [1:0] Sel_cu_go_back,
   output logic [1:0] Sel_adder,
   output logic       Is_save_cu_out
);

   localparam int CNT_MAX = (STEP_CYCLES > DRAIN_CYCLES) ? STEP_CYCLES : DRAIN_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   // Down-counters are loaded with N-1 so terminal count (0) lands on the Nth cycle.
   localparam logic [CW-1:0] STEP_LOAD  = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   localparam logic [1:0] OP_DOT  = 2'b00;
   localparam logic [1:0] OP_ELEM = 2'b01;
   localparam logic [1:0] OP_DIST = 2'b10;
   localparam logic [1:0] OP_ILL  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STEP   = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      step_q, step_d;
   logic [1:0]      cu_q, cu_d;
   logic [1:0]      gb_q, gb_d;
   logic [1:0]      ad_q, ad_d;
   logic            save_q, save_d;
   logic            err_q, err_d;

   logic            app_en;
   logic [1:0]      app_op;
   logic [2:0]      app_step;
   logic [2:0]      last_step;

   // State and all PE-facing controls are registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= 2'b00;
         cnt_q   <= '0;
         step_q  <= 3'd0;
         cu_q    <= 2'b00;
         gb_q    <= 2'b00;
         ad_q    <= 2'b00;
         save_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         cu_q    <= cu_d;
         gb_q    <= gb_d;
         ad_q    <= ad_d;
         save_q  <= save_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; a step only ever overwrites its own field so earlier fields stay held.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      step_d    = step_q;
      cu_d      = cu_q;
      gb_d      = gb_q;
      ad_d      = ad_q;
      save_d    = save_q;
      err_d     = 1'b0;
      app_en    = 1'b0;
      app_op    = op_q;
      app_step  = 3'd0;
      last_step = (op_q == OP_DIST) ? 3'd6 : 3'd2;

      case (state_q)
         S_IDLE: begin
            step_d = 3'd0;
            if (Start) begin
               if (Op == OP_ILL) begin
                  err_d = 1'b1;
               end else begin
                  op_d     = Op;
                  state_d  = S_STEP;
                  cnt_d    = STEP_LOAD;
                  app_en   = 1'b1;
                  app_op   = Op;
                  app_step = 3'd0;
               end
            end
         end
         S_STEP: begin
            if (Abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               step_d  = 3'd0;
               cu_d    = 2'b00;
               gb_d    = 2'b00;
               ad_d    = 2'b00;
               save_d  = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (step_q != last_step) begin
               step_d   = step_q + 3'd1;
               cnt_d    = STEP_LOAD;
               app_en   = 1'b1;
               app_step = step_q + 3'd1;
            end else if (DRAIN_CYCLES == 0) begin
               state_d = S_FINISH;
               cnt_d   = '0;
               step_d  = 3'd0;
               cu_d    = 2'b00;
               gb_d    = 2'b00;
               ad_d    = 2'b00;
               save_d  = 1'b0;
            end else begin
               state_d = S_DRAIN;
               cnt_d   = DRAIN_LOAD;
            end
         end
         S_DRAIN: begin
            if (Abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               step_d  = 3'd0;
               cu_d    = 2'b00;
               gb_d    = 2'b00;
               ad_d    = 2'b00;
               save_d  = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_FINISH;
               step_d  = 3'd0;
               cu_d    = 2'b00;
               gb_d    = 2'b00;
               ad_d    = 2'b00;
               save_d  = 1'b0;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (app_en) begin
         case ({app_op, app_step})
            {OP_DOT,  3'd0}: cu_d   = 2'b11;
            {OP_DOT,  3'd1}: gb_d   = 2'b10;
            {OP_DOT,  3'd2}: ad_d   = 2'b10;
            {OP_ELEM, 3'd0}: cu_d   = 2'b11;
            {OP_ELEM, 3'd1}: gb_d   = 2'b10;
            {OP_ELEM, 3'd2}: ad_d   = 2'b01;
            {OP_DIST, 3'd0}: cu_d   = 2'b10;
            {OP_DIST, 3'd1}: save_d = 1'b1;
            {OP_DIST, 3'd2}: gb_d   = 2'b01;
            {OP_DIST, 3'd3}: gb_d   = 2'b11;
            {OP_DIST, 3'd4}: cu_d   = 2'b11;
            {OP_DIST, 3'd5}: gb_d   = 2'b10;
            {OP_DIST, 3'd6}: ad_d   = 2'b10;
            default: ;
         endcase
      end
   end

   // Ready is gated by reset so every output reads 0 while reset is held.
   assign Ready          = (state_q == S_IDLE) & rst;
   assign Busy           = (state_q == S_STEP) | (state_q == S_DRAIN);
   assign Done           = (state_q == S_FINISH);
   assign Err            = err_q;
   assign Step_idx       = step_q;
   assign Sel_cu         = cu_q;
   assign Sel_cu_go_back = gb_q;
   assign Sel_adder      = ad_q;
   assign Is_save_cu_out = save_q;

endmodule

// File: tb/tb_pe_op_sequencer.sv
// Bench for pe_op_sequencer: one instance with default timing, one with
// STEP_CYCLES=1 / DRAIN_CYCLES=0, compared every cycle against a step-table model.
module tb_pe_op_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_a, abort_a, start_b, abort_b;
   logic [1:0] op_a, op_b;
   logic       ready_a, busy_a, done_a, err_a, save_a;
   logic       ready_b, busy_b, done_b, err_b, save_b;
   logic [2:0] step_a, step_b;
   logic [1:0] cu_a, gb_a, ad_a, cu_b, gb_b, ad_b;

   int checks = 0;
   int errors = 0;

   // Vector layout: {cu, go_back, adder, save, busy, done, ready, step_idx, err}
   localparam logic [13:0] IDLE_VEC = 14'h010;

   // Per-op step tables: field (0 cu, 1 go_back, 2 adder, 3 save) and value.
   int tab_f [3][7] = '{'{0, 1, 2, 0, 0, 0, 0}, '{0, 1, 2, 0, 0, 0, 0}, '{0, 3, 1, 1, 0, 1, 2}};
   int tab_v [3][7] = '{'{3, 2, 2, 0, 0, 0, 0}, '{3, 2, 1, 0, 0, 0, 0}, '{2, 1, 1, 3, 3, 2, 2}};

   pe_op_sequencer #(.STEP_CYCLES(10), .DRAIN_CYCLES(10)) dut_a (
      .clk(clk), .rst(rst), .Start(start_a), .Op(op_a), .Abort(abort_a),
      .Ready(ready_a), .Busy(busy_a), .Done(done_a), .Err(err_a), .Step_idx(step_a),
      .Sel_cu(cu_a), .Sel_cu_go_back(gb_a), .Sel_adder(ad_a), .Is_save_cu_out(save_a)
   );

   pe_op_sequencer #(.STEP_CYCLES(1), .DRAIN_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .Start(start_b), .Op(op_b), .Abort(abort_b),
      .Ready(ready_b), .Busy(busy_b), .Done(done_b), .Err(err_b), .Step_idx(step_b),
      .Sel_cu(cu_b), .Sel_cu_go_back(gb_b), .Sel_adder(ad_b), .Is_save_cu_out(save_b)
   );

   function automatic logic [13:0] obs(input int sel);
      if (sel != 0)
         return {cu_b, gb_b, ad_b, save_b, busy_b, done_b, ready_b, step_b, err_b};
      else
         return {cu_a, gb_a, ad_a, save_a, busy_a, done_a, ready_a, step_a, err_a};
   endfunction

   // Expected outputs t cycles after the accepting edge.
   function automatic logic [13:0] model(input int op, input int s, input int d,
                                         input int t, input int abort_t);
      int         n_steps, tot, n;
      logic [1:0] cu, gb, ad;
      logic       sv, busy, done, ready;
      logic [2:0] stp;
      n_steps = (op == 2) ? 7 : 3;
      tot     = n_steps * s + d;
      cu = 2'b00; gb = 2'b00; ad = 2'b00; sv = 1'b0;
      busy = 1'b0; done = 1'b0; ready = 1'b0; stp = 3'd0;
      if (abort_t >= 0 && t > abort_t) begin
         ready = 1'b1;
      end else if (t == tot) begin
         done = 1'b1;
      end else if (t > tot) begin
         ready = 1'b1;
      end else begin
         busy = 1'b1;
         n = t / s;
         if (n > n_steps - 1) n = n_steps - 1;
         stp = 3'(n);
         for (int i = 0; i <= n; i++) begin
            case (tab_f[op][i])
               0: cu = 2'(tab_v[op][i]);
               1: gb = 2'(tab_v[op][i]);
               2: ad = 2'(tab_v[op][i]);
               default: sv = 1'b1;
            endcase
         end
      end
      return {cu, gb, ad, sv, busy, done, ready, stp, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [13:0] o, input logic [13:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [1:0] o, input logic ab);
      if (sel != 0) begin
         start_b = st; op_b = o; abort_b = ab;
      end else begin
         start_a = st; op_a = o; abort_a = ab;
      end
   endtask

   // Accept one operation at the next edge and check every cycle until idle.
   // abort_t / xs < 0 disable the abort / the ignored mid-run Start.
   task automatic run_op(input int sel, input int op, input int abort_t, input int xs);
      int s, d, tot;
      bit stop;
      s    = (sel != 0) ? 1 : 10;
      d    = (sel != 0) ? 0 : 10;
      tot  = ((op == 2) ? 7 : 3) * s + d;
      stop = 0;
      check($sformatf("ready_pre dut%0d", sel), obs(sel), IDLE_VEC);
      drive(sel, 1'b1, 2'(op), 1'($urandom_range(0, 1)));
      @(negedge clk);
      for (int t = 0; t <= tot && !stop; t++) begin
         check($sformatf("run dut%0d op%0d t%0d ab%0d", sel, op, t, abort_t), obs(sel),
               model(op, s, d, t, abort_t));
         drive(sel, 1'((t == xs) && !(abort_t >= 0 && t > abort_t)),
               2'($urandom_range(0, 3)), 1'(t == abort_t));
         if (abort_t >= 0 && t == abort_t + 1) stop = 1;
         else @(negedge clk);
      end
      drive(sel, 1'b0, 2'b00, 1'b0);
      if (stop) begin
         repeat (2) begin
            @(negedge clk);
            check($sformatf("post_abort dut%0d", sel), obs(sel), IDLE_VEC);
         end
      end
   endtask

   initial begin
      int op, ab, xs, tot;
      rst = 1'b0;
      drive(0, 1'b0, 2'b00, 1'b0);
      drive(1, 1'b0, 2'b00, 1'b0);
      repeat (3) @(negedge clk);
      check("in_reset a", obs(0), 14'h0);
      check("in_reset b", obs(1), 14'h0);
      rst = 1'b1;
      #1;
      check("after_reset a", obs(0), IDLE_VEC);
      check("after_reset b", obs(1), IDLE_VEC);
      @(negedge clk);

      // DOT, ELEM with ignored Start at k+5, DIST
      run_op(0, 0, -1, -1);
      run_op(0, 1, -1, 5);
      run_op(0, 2, -1, -1);

      // Illegal op: Err for exactly one cycle, stays idle
      drive(0, 1'b1, 2'b11, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 2'b00, 1'b0);
      check("err_pulse", obs(0), IDLE_VEC | 14'h001);
      @(negedge clk);
      check("err_clear", obs(0), IDLE_VEC);

      // Abort during DOT step 1
      run_op(0, 0, 12, -1);

      // Asynchronous reset in the middle of DIST step 3
      drive(0, 1'b1, 2'b10, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 2'b00, 1'b0);
      repeat (35) @(negedge clk);
      check("dist_s3", obs(0), model(2, 10, 10, 35, -1));
      #2 rst = 1'b0;
      #1;
      check("async_reset", obs(0), 14'h0);
      @(negedge clk);
      check("reset_held", obs(0), 14'h0);
      rst = 1'b1;
      #1;
      check("reset_release", obs(0), IDLE_VEC);
      @(negedge clk);

      // Fast instance: DOT done at k+3, then back-to-back accepts
      run_op(1, 0, -1, -1);
      run_op(1, 0, -1, -1);
      run_op(1, 2, -1, -1);

      // Randomized runs on both instances
      repeat (8) begin
         op  = $urandom_range(0, 2);
         tot = ((op == 2) ? 7 : 3) * 10 + 10;
         ab  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, tot - 1) : -1;
         xs  = $urandom_range(0, tot - 1);
         run_op(0, op, ab, xs);
      end
      repeat (12) begin
         op  = $urandom_range(0, 2);
         tot = (op == 2) ? 7 : 3;
         ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, tot - 1) : -1;
         xs  = $urandom_range(0, tot - 1);
         run_op(1, op, ab, xs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
